// File: rtl/fb_rect_compositor_if.sv
// fb_rect_compositor_if: rectangle-slot write bus and framebuffer pixel-write bus.
//   rect_wr/rect_idx/rect_x0..rect_y1/rect_color/rect_en : shadow slot write
//   commit                                          : request shadow->active copy at next frame start
//   fb_vsync/fb_we/fb_data/frame_done               : paced pixel stream to the framebuffer
// The compositor is the slave: it consumes slot writes and produces the pixel stream.
interface fb_rect_compositor_if #(
  parameter int COLOR_BITS = 18,
  parameter int IDX_BITS = 2
);
  logic rect_wr;
  logic [IDX_BITS-1:0] rect_idx;
  logic [9:0] rect_x0, rect_y0, rect_x1, rect_y1;
  logic [COLOR_BITS-1:0] rect_color;
  logic rect_en;
  logic commit;
  logic fb_vsync;
  logic fb_we;
  logic [COLOR_BITS-1:0] fb_data;
  logic frame_done;
  modport master (
    output rect_wr, rect_idx, rect_x0, rect_y0, rect_x1, rect_y1, rect_color, rect_en, commit,
    input fb_vsync, fb_we, fb_data, frame_done
  );
  modport slave (
    input rect_wr, rect_idx, rect_x0, rect_y0, rect_x1, rect_y1, rect_color, rect_en, commit,
    output fb_vsync, fb_we, fb_data, frame_done
  );
endinterface

// File: rtl/fb_rect_compositor.sv
// fb_rect_compositor: raster-order rectangle compositor feeding a paced framebuffer write port.
//   clk, rst_n (async, active-low) : clock and reset
//   enable    : run frames continuously while high
//   bg_color  : colour of pixels no enabled rectangle covers
//   bus       : slot writes + commit in, fb_vsync/fb_we/fb_data/frame_done out
//   frame_cnt : frames started, wraps at 16 bits
module fb_rect_compositor #(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int COLOR_BITS = 18,
  parameter int PIX_PERIOD = 4,
  parameter int NUM_RECTS = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic [COLOR_BITS-1:0] bg_color,
  fb_rect_compositor_if.slave bus,
  output logic [15:0] frame_cnt
);
  localparam int IW = NUM_RECTS > 1 ? $clog2(NUM_RECTS) : 1;
  localparam int PW = $clog2(PIX_PERIOD);
  localparam logic [PW-1:0] PACE_LD = PW'(PIX_PERIOD - 1);
  localparam logic [9:0] X_LAST = 10'(WIDTH - 1);
  localparam logic [9:0] Y_LAST = 10'(HEIGHT - 1);
  typedef enum logic [1:0] {IDLE, VSYNC, PIXEL} state_t;
  typedef struct packed {
    logic en;
    logic [9:0] x0, y0, x1, y1;
    logic [COLOR_BITS-1:0] color;
  } rect_t;
  state_t state, nxt;
  rect_t shadow [NUM_RECTS];
  rect_t active [NUM_RECTS];
  logic [9:0] x, y;
  logic [PW-1:0] pace;
  logic pending, tick, last;
  logic [COLOR_BITS-1:0] color, data_q;
  logic vsync_q, we_q, done_q;
  assign tick = state == PIXEL && pace == '0;
  assign last = tick && x == X_LAST && y == Y_LAST;
  assign bus.fb_vsync = vsync_q;
  assign bus.fb_we = we_q;
  assign bus.fb_data = data_q;
  assign bus.frame_done = done_q;
  always_comb begin
    nxt = state == IDLE ? (enable ? VSYNC : IDLE) :
          state == VSYNC ? PIXEL :
          last ? (enable ? VSYNC : IDLE) : PIXEL;
  end
  // Walk from lowest priority to highest so the lowest covering index wins.
  always_comb begin
    color = bg_color;
    for (int i = NUM_RECTS - 1; i >= 0; i--)
      if (active[i].en && x >= active[i].x0 && x < active[i].x1 &&
          y >= active[i].y0 && y < active[i].y1)
        color = active[i].color;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
      pace <= '0;
      pending <= 1'b0;
      frame_cnt <= '0;
      vsync_q <= 1'b0;
      we_q <= 1'b0;
      done_q <= 1'b0;
      data_q <= '0;
      for (int i = 0; i < NUM_RECTS; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      // Outputs lag the state by one cycle so every output is a plain register.
      vsync_q <= state == VSYNC;
      we_q <= tick;
      done_q <= last;
      if (tick) data_q <= color;
      if (bus.rect_wr)
        shadow[IW'(bus.rect_idx)] <= {bus.rect_en, bus.rect_x0, bus.rect_y0,
                                      bus.rect_x1, bus.rect_y1, bus.rect_color};
      // A commit in the VSYNC cycle survives the clear and applies next frame.
      pending <= bus.commit | (pending & (state != VSYNC));
      if (state == VSYNC) begin
        frame_cnt <= frame_cnt + 16'd1;
        x <= '0;
        y <= '0;
        pace <= PACE_LD;
        if (pending) active <= shadow;
      end
      if (state == PIXEL) begin
        pace <= tick ? PACE_LD : pace - 1'b1;
        if (tick) begin
          x <= x == X_LAST ? '0 : x + 10'd1;
          y <= x == X_LAST ? y + 10'd1 : y;
        end
      end
    end
  end
endmodule

// File: tb/tb_fb_rect_compositor.sv
// tb_fb_rect_compositor: scoreboard bench for fb_rect_compositor at WIDTH=8 HEIGHT=4 PIX_PERIOD=2.
module tb_fb_rect_compositor;
  localparam int W = 8, H = 4, P = 2, N = 4, CB = 18;
  typedef struct {
    bit en;
    int x0, y0, x1, y1;
    logic [CB-1:0] c;
  } slot_t;
  logic clk = 0, rst_n = 1, enable = 0;
  logic [CB-1:0] bg_color = '0;
  logic [15:0] frame_cnt;
  int cyc = 0;
  int checks = 0, errors = 0;
  slot_t m_sh [N];
  slot_t m_act [N];
  logic [CB-1:0] q [$];
  fb_rect_compositor_if #(.COLOR_BITS(CB), .IDX_BITS(2)) bus ();
  fb_rect_compositor #(.WIDTH(W), .HEIGHT(H), .COLOR_BITS(CB), .PIX_PERIOD(P), .NUM_RECTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .bg_color(bg_color), .bus(bus), .frame_cnt(frame_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [CB-1:0] mcol(input int x, input int y);
    mcol = bg_color;
    for (int i = N - 1; i >= 0; i--)
      if (m_act[i].en && x >= m_act[i].x0 && x < m_act[i].x1 && y >= m_act[i].y0 && y < m_act[i].y1)
        mcol = m_act[i].c;
  endfunction
  task push_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) q.push_back(mcol(x, y));
  endtask
  task apply_commit();
    for (int i = 0; i < N; i++) m_act[i] = m_sh[i];
  endtask
  task set_rect(input int i, input int x0, input int y0, input int x1, input int y1,
                input logic [CB-1:0] c, input bit en);
    bus.rect_wr = 1;
    bus.rect_idx = 2'(i);
    bus.rect_x0 = 10'(x0);
    bus.rect_y0 = 10'(y0);
    bus.rect_x1 = 10'(x1);
    bus.rect_y1 = 10'(y1);
    bus.rect_color = c;
    bus.rect_en = en;
    m_sh[i] = '{en, x0, y0, x1, y1, c};
  endtask
  task write_rect(input int i, input int x0, input int y0, input int x1, input int y1,
                  input logic [CB-1:0] c, input bit en);
    @(negedge clk);
    set_rect(i, x0, y0, x1, y1, c, en);
    @(negedge clk);
    bus.rect_wr = 0;
  endtask
  task pulse_commit();
    @(negedge clk);
    bus.commit = 1;
    @(negedge clk);
    bus.commit = 0;
  endtask
  task do_reset();
    rst_n = 0;
    enable = 0;
    bus.rect_wr = 0;
    bus.commit = 0;
    bus.rect_idx = '0;
    bus.rect_x0 = '0;
    bus.rect_y0 = '0;
    bus.rect_x1 = '0;
    bus.rect_y1 = '0;
    bus.rect_color = '0;
    bus.rect_en = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < N; i++) begin
      m_sh[i] = '{0, 0, 0, 0, 0, '0};
      m_act[i] = '{0, 0, 0, 0, 0, '0};
    end
    q.delete();
  endtask
  // Waits for fb_vsync, then checks one frame of pixels against the queue.
  // act at pixel act_at: 1 commit full-screen slot 0, 2 slot write without commit, 3 drop enable, 4 reset.
  task collect_frame(input int act_at, input int act, output int t0, output int wait_n);
    int n;
    bit seen, done_seen, aborted;
    logic [CB-1:0] exp;
    seen = 0;
    t0 = 0;
    wait_n = -1;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (bus.fb_vsync) begin
        seen = 1;
        wait_n = i;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL vsync_timeout: no fb_vsync within 300 cycles");
      return;
    end
    t0 = cyc;
    n = 0;
    done_seen = 0;
    aborted = 0;
    for (int i = 0; i < W * H * P && !aborted; i++) begin
      @(negedge clk);
      bus.rect_wr = 0;
      bus.commit = 0;
      checks++;
      if (bus.fb_we && bus.fb_vsync) begin
        errors++;
        $display("FAIL we_vsync_overlap at cycle %0d", cyc - t0);
      end
      if (bus.fb_we) begin
        checks++;
        if (cyc - t0 != (n + 1) * P) begin
          errors++;
          $display("FAIL pix_time pixel %0d: got T+%0d want T+%0d", n, cyc - t0, (n + 1) * P);
        end
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL extra_pixel %0d: got data %h, none expected", n, bus.fb_data);
        end else begin
          exp = q.pop_front();
          if (bus.fb_data !== exp) begin
            errors++;
            $display("FAIL pix_data (%0d,%0d): got %h want %h", n % W, n / W, bus.fb_data, exp);
          end
        end
        n++;
        if (n == act_at) begin
          if (act == 1) begin
            set_rect(0, 0, 0, W, H, 18'h3FFFF, 1);
            bus.commit = 1;
          end
          if (act == 2) set_rect(0, 0, 0, W, H, 18'h11111, 1);
          if (act == 3) enable = 0;
          if (act == 4) begin
            rst_n = 0;
            #1;
            checks++;
            if (bus.fb_we !== 0 || bus.fb_vsync !== 0 || bus.frame_done !== 0 || frame_cnt !== 0) begin
              errors++;
              $display("FAIL async_reset: we=%b vsync=%b done=%b cnt=%0d want all 0",
                       bus.fb_we, bus.fb_vsync, bus.frame_done, frame_cnt);
            end
            repeat (3) @(negedge clk);
            rst_n = 1;
            aborted = 1;
          end
        end
      end
      if (!aborted && bus.frame_done) begin
        done_seen = 1;
        checks++;
        if (!(bus.fb_we === 1 && n == W * H)) begin
          errors++;
          $display("FAIL done_pos: frame_done with we=%b after %0d pixels, want we=1 after %0d",
                   bus.fb_we, n, W * H);
        end
      end
    end
    if (aborted) return;
    checks++;
    if (n != W * H || !done_seen) begin
      errors++;
      $display("FAIL pix_count: got %0d pixels done=%b want %0d done=1", n, done_seen, W * H);
    end
  endtask
  task test_reset();
    int vs;
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.fb_we !== 0 || bus.fb_vsync !== 0 || bus.frame_done !== 0 || bus.fb_data !== '0 || frame_cnt !== 0) begin
      errors++;
      $display("FAIL reset_values: we=%b vsync=%b done=%b data=%h cnt=%0d want all 0",
               bus.fb_we, bus.fb_vsync, bus.frame_done, bus.fb_data, frame_cnt);
    end
    vs = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.fb_vsync || bus.fb_we) vs++;
    end
    checks++;
    if (vs != 0) begin
      errors++;
      $display("FAIL idle_quiet: got %0d strobes while disabled, want 0", vs);
    end
  endtask
  task test_background();
    int ta, tb, wn;
    do_reset();
    bg_color = 18'h15555;
    @(negedge clk);
    enable = 1;
    push_frame();
    collect_frame(-1, 0, ta, wn);
    checks++;
    if (wn != 1) begin
      errors++;
      $display("FAIL vsync_latency: got %0d want 1", wn);
    end
    push_frame();
    collect_frame(-1, 0, tb, wn);
    checks++;
    if (tb - ta != W * H * P + 1) begin
      errors++;
      $display("FAIL frame_period: got %0d want %0d", tb - ta, W * H * P + 1);
    end
    checks++;
    if (frame_cnt !== 16'd2) begin
      errors++;
      $display("FAIL frame_cnt: got %0d want 2", frame_cnt);
    end
  endtask
  task test_priority();
    int t, wn;
    do_reset();
    bg_color = 18'h00001;
    write_rect(0, 2, 1, 4, 3, 18'h3F000, 1);
    write_rect(1, 0, 0, 8, 4, 18'h00FC0, 1);
    pulse_commit();
    apply_commit();
    enable = 1;
    push_frame();
    collect_frame(-1, 0, t, wn);
  endtask
  task test_empty_disabled();
    int t, wn;
    do_reset();
    bg_color = 18'h2AAAA;
    write_rect(0, 5, 0, 5, 4, 18'h0000F, 1);
    write_rect(1, 0, 0, 8, 4, 18'h3FFFF, 0);
    pulse_commit();
    apply_commit();
    enable = 1;
    push_frame();
    collect_frame(-1, 0, t, wn);
  endtask
  task test_commit_boundary();
    int t, wn;
    do_reset();
    bg_color = 18'h00AAA;
    enable = 1;
    push_frame();
    collect_frame(10, 1, t, wn);
    apply_commit();
    push_frame();
    collect_frame(5, 2, t, wn);
    push_frame();
    collect_frame(-1, 0, t, wn);
  endtask
  task test_enable_drop();
    int t, wn, vs;
    do_reset();
    bg_color = 18'h01234;
    enable = 1;
    push_frame();
    collect_frame(10, 3, t, wn);
    vs = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.fb_vsync || bus.fb_we) vs++;
    end
    checks++;
    if (vs != 0) begin
      errors++;
      $display("FAIL enable_drop_stop: got %0d strobes after frame, want 0", vs);
    end
  endtask
  task test_reset_midframe();
    int t, wn;
    do_reset();
    bg_color = 18'h0BEEF;
    enable = 1;
    push_frame();
    collect_frame(5, 4, t, wn);
    q.delete();
    push_frame();
    collect_frame(-1, 0, t, wn);
    checks++;
    if (wn != 1) begin
      errors++;
      $display("FAIL restart_latency: got %0d want 1", wn);
    end
    checks++;
    if (frame_cnt !== 16'd1) begin
      errors++;
      $display("FAIL restart_cnt: got %0d want 1", frame_cnt);
    end
  endtask
  initial begin
    test_reset();
    test_background();
    test_priority();
    test_empty_disabled();
    test_commit_boundary();
    test_enable_drop();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
